// File: rtl/rv32i_alu.sv
// rv32i_alu: registered integer ALU for the RV32I single-cycle datapath.
// This module covers the RV32I register and immediate operations: arithmetic,
// logic, compares and shifts. It also has a pass-through of operand B, which
// LUI uses. Results appear one clock after the operands are sampled.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-low reset
//   io_sel       operation select (ALU_SEL_* encodings below)
//   io_in_a      operand A
//   io_in_b      operand B; the low log2(DATA_WIDTH) bits are the shift amount
//   io_in_valid  marks the current inputs as a real operation
//   io_out       registered result
//   io_out_valid registered copy of io_in_valid
//   io_zero      (ALU_FLAGS_EN only) registered "result is zero" flag
//   io_neg       (ALU_FLAGS_EN only) registered result MSB
//
// Optional feature macro: ALU_FLAGS_EN adds the io_zero/io_neg flag outputs.

`ifndef ALU_SEL_WIDTH
`define ALU_SEL_WIDTH 4
`define ALU_SEL_ADD   0
`define ALU_SEL_SUB   1
`define ALU_SEL_SLL   2
`define ALU_SEL_SLT   3
`define ALU_SEL_SLTU  4
`define ALU_SEL_XOR   5
`define ALU_SEL_SRL   6
`define ALU_SEL_SRA   7
`define ALU_SEL_OR    8
`define ALU_SEL_AND   9
`define ALU_SEL_COPYB 10
`endif

module rv32i_alu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = `ALU_SEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_WIDTH-1:0]  io_sel,
  input  logic [DATA_WIDTH-1:0] io_in_a,
  input  logic [DATA_WIDTH-1:0] io_in_b,
  input  logic                  io_in_valid,
`ifdef ALU_FLAGS_EN
  output logic                  io_zero,
  output logic                  io_neg,
`endif
  output logic [DATA_WIDTH-1:0] io_out,
  output logic                  io_out_valid
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [SEL_WIDTH-1:0] SEL_ADD   = SEL_WIDTH'(`ALU_SEL_ADD);
  localparam logic [SEL_WIDTH-1:0] SEL_SUB   = SEL_WIDTH'(`ALU_SEL_SUB);
  localparam logic [SEL_WIDTH-1:0] SEL_SLL   = SEL_WIDTH'(`ALU_SEL_SLL);
  localparam logic [SEL_WIDTH-1:0] SEL_SLT   = SEL_WIDTH'(`ALU_SEL_SLT);
  localparam logic [SEL_WIDTH-1:0] SEL_SLTU  = SEL_WIDTH'(`ALU_SEL_SLTU);
  localparam logic [SEL_WIDTH-1:0] SEL_XOR   = SEL_WIDTH'(`ALU_SEL_XOR);
  localparam logic [SEL_WIDTH-1:0] SEL_SRL   = SEL_WIDTH'(`ALU_SEL_SRL);
  localparam logic [SEL_WIDTH-1:0] SEL_SRA   = SEL_WIDTH'(`ALU_SEL_SRA);
  localparam logic [SEL_WIDTH-1:0] SEL_OR    = SEL_WIDTH'(`ALU_SEL_OR);
  localparam logic [SEL_WIDTH-1:0] SEL_AND   = SEL_WIDTH'(`ALU_SEL_AND);
  localparam logic [SEL_WIDTH-1:0] SEL_COPYB = SEL_WIDTH'(`ALU_SEL_COPYB);

  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] result;

  // Bits of B above the shift-amount field play no part in shifts.
  assign shamt = io_in_b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    unique case (io_sel)
      SEL_ADD:   result = io_in_a + io_in_b;
      SEL_SUB:   result = io_in_a - io_in_b;
      SEL_SLL:   result = io_in_a << shamt;
      SEL_SLT:   result = DATA_WIDTH'($signed(io_in_a) < $signed(io_in_b));
      SEL_SLTU:  result = DATA_WIDTH'(io_in_a < io_in_b);
      SEL_XOR:   result = io_in_a ^ io_in_b;
      SEL_SRL:   result = io_in_a >> shamt;
      SEL_SRA:   result = $unsigned($signed(io_in_a) >>> shamt);
      SEL_OR:    result = io_in_a | io_in_b;
      SEL_AND:   result = io_in_a & io_in_b;
      SEL_COPYB: result = io_in_b;
      default:   result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      io_out       <= '0;
      io_out_valid <= 1'b0;
    end else begin
      io_out       <= result;
      io_out_valid <= io_in_valid;
    end
  end

`ifdef ALU_FLAGS_EN
  // The flags are derived from the same next-state value that io_out loads.
  // This keeps them aligned with io_out on every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_zero <= 1'b0;
      io_neg  <= 1'b0;
    end else begin
      io_zero <= (result == '0);
      io_neg  <= result[DATA_WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_alu.sv
// tb_rv32i_alu: scoreboard bench for rv32i_alu.
// The stimulus issuer pushes the expected response for each issued cycle.
// A separate monitor pops the queue and compares one cycle later.
// The reference model computes results with plain integer arithmetic.

module tb_rv32i_alu;

  logic        clk;
  logic        rst;
  logic [3:0]  io_sel;
  logic [31:0] io_in_a;
  logic [31:0] io_in_b;
  logic        io_in_valid;
  logic [31:0] io_out;
  logic        io_out_valid;
`ifdef ALU_FLAGS_EN
  logic        io_zero;
  logic        io_neg;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] out;
    logic        valid;
    logic        zero;
    logic        neg;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  rv32i_alu #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_sel       (io_sel),
    .io_in_a      (io_in_a),
    .io_in_b      (io_in_b),
    .io_in_valid  (io_in_valid),
`ifdef ALU_FLAGS_EN
    .io_zero      (io_zero),
    .io_neg       (io_neg),
`endif
    .io_out       (io_out),
    .io_out_valid (io_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from the operation definitions, using 64-bit arithmetic.
  function automatic logic [31:0] ref_alu(input int unsigned sel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua  = 64'(a);
    longint unsigned ub  = 64'(b);
    longint unsigned two = 64'd1 << 32;
    longint unsigned p   = 64'd1 << (b % 32);
    longint unsigned r;
    case (sel)
      0:  r = (ua + ub) % two;
      1:  r = (ua + two - ub) % two;
      2:  r = (ua * p) % two;
      3:  r = ((ua ^ 64'h8000_0000) < (ub ^ 64'h8000_0000)) ? 64'd1 : 64'd0;
      4:  r = (ua < ub) ? 64'd1 : 64'd0;
      5:  r = ua ^ ub;
      6:  r = ua / p;
      // Arithmetic right shift is floor division by 2^s.
      // For a negative value, this equals ~((~a) / 2^s).
      7:  r = a[31] ? ((two - 1) ^ (((two - 1) ^ ua) / p)) : ua / p;
      8:  r = ua | ub;
      9:  r = ua & ub;
      10: r = ub;
      default: r = 64'd0;
    endcase
    return r[31:0];
  endfunction

  // Issue one cycle of stimulus and record its expected response.
  task automatic send(input logic r, input logic [3:0] sel,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic v, input logic [31:0] expv,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst         = r;
    io_sel      = sel;
    io_in_a     = a;
    io_in_b     = b;
    io_in_valid = v;
    e.out   = r ? expv : 32'h0;
    e.valid = r ? v : 1'b0;
    e.zero  = r ? (expv == 32'h0) : 1'b0;
    e.neg   = r ? expv[31] : 1'b0;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a registered result.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (io_out !== e.out) begin
        errors++;
        $display("FAIL %s out: got %08h expected %08h", e.name, io_out, e.out);
      end
      checks++;
      if (io_out_valid !== e.valid) begin
        errors++;
        $display("FAIL %s valid: got %0b expected %0b", e.name, io_out_valid, e.valid);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (io_zero !== e.zero || io_neg !== e.neg) begin
        errors++;
        $display("FAIL %s flags: got z=%0b n=%0b expected z=%0b n=%0b",
                 e.name, io_zero, io_neg, e.zero, e.neg);
      end
`endif
    end
  end

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expv;
    string       name;
  } vec_t;

  vec_t dir[$];

  initial begin
    rst = 1'b0; io_sel = 4'd0; io_in_a = '0; io_in_b = '0; io_in_valid = 1'b0;

    // Hold reset for two edges while presenting a valid ADD.
    send(1'b0, 4'd0, 32'd3, 32'd4, 1'b1, 32'h0, "reset0");
    send(1'b0, 4'd0, 32'd3, 32'd4, 1'b1, 32'h0, "reset1");
    send(1'b1, 4'd0, 32'd3, 32'd4, 1'b1, 32'd7, "first_after_reset");

    dir.push_back('{4'd0,  32'hFFFFFF9C, 32'hC8, 32'h00000064, "add"});
    dir.push_back('{4'd1,  32'hFFFFFF9C, 32'hC8, 32'hFFFFFED4, "sub"});
    dir.push_back('{4'd3,  32'hFFFFFF9C, 32'hC8, 32'h00000001, "slt"});
    dir.push_back('{4'd4,  32'hFFFFFF9C, 32'hC8, 32'h00000000, "sltu"});
    dir.push_back('{4'd5,  32'hFFFFFF9C, 32'hC8, 32'hFFFFFF54, "xor"});
    dir.push_back('{4'd8,  32'hFFFFFF9C, 32'hC8, 32'hFFFFFFDC, "or"});
    dir.push_back('{4'd9,  32'hFFFFFF9C, 32'hC8, 32'h00000088, "and"});
    dir.push_back('{4'd10, 32'hFFFFFF9C, 32'hC8, 32'h000000C8, "copyb"});
    dir.push_back('{4'd2,  32'hFFFFFF9C, 32'd20, 32'hF9C00000, "sll20"});
    dir.push_back('{4'd6,  32'hFFFFFF9C, 32'd20, 32'h00000FFF, "srl20"});
    dir.push_back('{4'd7,  32'hFFFFFF9C, 32'd20, 32'hFFFFFFFF, "sra20"});
    dir.push_back('{4'd1,  32'h0,        32'h1,  32'hFFFFFFFF, "sub_wrap"});
    dir.push_back('{4'd0,  32'hFFFFFFFF, 32'h1,  32'h00000000, "add_wrap"});
    dir.push_back('{4'd2,  32'h1,        32'd33, 32'h00000002, "sll_b33"});
    dir.push_back('{4'd6,  32'h1234ABCD, 32'd0,  32'h1234ABCD, "srl_zero"});
    dir.push_back('{4'd7,  32'h80000000, 32'd32, 32'h80000000, "sra_b32"});
    dir.push_back('{4'd3,  32'h80000000, 32'h0,  32'h00000001, "slt_min"});
    dir.push_back('{4'd4,  32'h80000000, 32'h0,  32'h00000000, "sltu_min"});
    dir.push_back('{4'd3,  32'h7,        32'h7,  32'h00000000, "slt_eq"});
    dir.push_back('{4'd4,  32'h7,        32'h7,  32'h00000000, "sltu_eq"});
    dir.push_back('{4'd15, 32'hDEADBEEF, 32'h5,  32'h00000000, "sel15"});
    dir.push_back('{4'd11, 32'hDEADBEEF, 32'h5,  32'h00000000, "sel11"});
    dir.push_back('{4'd1,  32'd5,        32'd5,  32'h00000000, "sub_zero"});

    // Back-to-back directed issue.
    // This also covers the pipelining case: the select changes every cycle and valid toggles.
    foreach (dir[i])
      send(1'b1, dir[i].sel, dir[i].a, dir[i].b, (i % 2 == 0), dir[i].expv, dir[i].name);

    // Randomized operations against the reference model.
    for (int unsigned n = 0; n < 300; n++) begin
      logic [3:0]  s;
      logic [31:0] a;
      logic [31:0] b;
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (n % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send(1'b1, s, a, b, 1'($urandom_range(0, 1)), ref_alu(s, a, b), "random");
    end

    // Mid-stream reset must override the operation in that cycle.
    send(1'b0, 4'd10, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0, "reset_mid");
    send(1'b1, 4'd10, 32'h0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, "after_reset_mid");

    // Drain the scoreboard within a bounded number of cycles.
    for (int unsigned w = 0; w < 20 && exp_q.size() > 0; w++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
